// File: rtl/cmd_sequencer_pkg.sv
// Shared types and constants for the command sequencer and its queue.
package cmd_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_RESP = 2'd2,
        CHECK     = 2'd3
    } seq_state_e;

    // Response byte that acknowledges a command.
    localparam logic [7:0] POS_ACK = 8'hA5;

    // err_code values, qualified by err.
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_NAK     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // Command opcodes understood by the remote side.
    localparam logic [7:0] CMD_OP_02 = 8'h02;
    localparam logic [7:0] CMD_OP_03 = 8'h03;
    localparam logic [7:0] CMD_OP_04 = 8'h04;
    localparam logic [7:0] CMD_OP_05 = 8'h05;
    localparam logic [7:0] CMD_OP_06 = 8'h06;
    localparam logic [7:0] CMD_OP_07 = 8'h07;
    localparam logic [7:0] CMD_OP_08 = 8'h08;
    localparam logic [7:0] CMD_OP_MIN = CMD_OP_02;
    localparam logic [7:0] CMD_OP_MAX = CMD_OP_08;

endpackage

// File: rtl/cmd_sequencer_fifo.sv
// cmd_fifo: DEPTH-entry synchronous FIFO holding {opcode, payload} words.
// A push while full is accepted only if a pop happens in the same cycle;
// otherwise it is dropped and ovf pulses.
module cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 24
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         full,
    output logic                         empty,
    output logic                         ovf,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        ovf      = push && !do_push;
        if (do_push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    // Storage and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/cmd_sequencer.sv
// cmd_sequencer: queues commands and issues them one at a time to RemoteComm,
// waiting for an 8-bit response (A5 = ack) or a timeout.
// Optional: define CMD_SEQUENCER_RETRY_EN to re-send a failed command up to
// MAX_RETRY times before reporting err.
module cmd_sequencer
    import cmd_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned TIMEOUT_CYC = 500000,
    parameter int unsigned MAX_RETRY   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic [7:0]  push_cmd,
    input  logic [15:0] push_data,
    output logic        push_rdy,
    output logic        ovf,
    output logic        send_cmd,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    input  logic        resp_rdy,
    input  logic [7:0]  resp,
    output logic        clr_resp_rdy,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code
);

`ifdef CMD_SEQUENCER_RETRY_EN
    localparam bit RETRY_ON = 1'b1;
`else
    localparam bit RETRY_ON = 1'b0;
`endif

    localparam int unsigned TW = $clog2(TIMEOUT_CYC+1);
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY+1) : 1;
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC-1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    seq_state_e state_q, state_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [15:0]   data_q, data_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [RW-1:0] retry_q, retry_d;

    logic                        pop;
    logic                        fail;
    logic [1:0]                  fail_code;
    logic [23:0]                 fifo_rd_data;
    logic                        fifo_full, fifo_empty;
    logic [$clog2(DEPTH+1)-1:0]  fifo_count;

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (24)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data ({push_cmd, push_data}),
        .pop     (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .ovf     (ovf),
        .count   (fifo_count)
    );

    assign push_rdy = !fifo_full;
    assign busy     = (state_q != IDLE) || (fifo_count != '0);
    assign cmd      = cmd_q;
    assign data     = data_q;

    // Next-state and pulse outputs. The head is popped on the IDLE->LAUNCH edge so that
    // cmd/data are already valid during the send_cmd cycle; retries re-enter LAUNCH without popping.
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        data_d       = data_q;
        tmo_d        = tmo_q;
        retry_d      = retry_q;
        pop          = 1'b0;
        send_cmd     = 1'b0;
        clr_resp_rdy = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        err_code     = ERR_NONE;
        fail         = 1'b0;
        fail_code    = ERR_NONE;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop             = 1'b1;
                    {cmd_d, data_d} = fifo_rd_data;
                    state_d         = LAUNCH;
                end
            end
            LAUNCH: begin
                send_cmd = 1'b1;
                tmo_d    = '0;
                state_d  = WAIT_RESP;
            end
            WAIT_RESP: begin
                if (resp_rdy) begin
                    state_d = CHECK;
                end else if (tmo_q == TMO_LAST) begin
                    fail      = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            CHECK: begin
                clr_resp_rdy = 1'b1;
                if (resp == POS_ACK) begin
                    done    = 1'b1;
                    retry_d = '0;
                    state_d = IDLE;
                end else begin
                    fail      = 1'b1;
                    fail_code = ERR_NAK;
                end
            end
            default: state_d = IDLE;
        endcase
        if (fail) begin
            if (RETRY_ON && (retry_q < RETRY_MAX)) begin
                retry_d = retry_q + 1'b1;
                state_d = LAUNCH;
            end else begin
                err      = 1'b1;
                err_code = fail_code;
                retry_d  = '0;
                state_d  = IDLE;
            end
        end
    end

    // State, held command and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            data_q  <= '0;
            tmo_q   <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            data_q  <= data_d;
            tmo_q   <= tmo_d;
            retry_q <= retry_d;
        end
    end

endmodule

// File: tb/tb_cmd_sequencer.sv
// Self-checking bench for cmd_sequencer: every cycle is compared against an
// event-schedule reference model; a vector table plus hand sequences cover
// latency, NAK, timeout, tie-break, overflow and mid-transaction reset.
`timescale 1ns/1ps
module tb_cmd_sequencer;
    import cmd_sequencer_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 1000;
    localparam int unsigned MAXR  = 2;
`ifdef CMD_SEQUENCER_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        push = 1'b0;
    logic [7:0]  push_cmd = '0;
    logic [15:0] push_data = '0;
    logic        push_rdy, ovf, send_cmd, clr_resp_rdy, busy, done, err;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        resp_rdy = 1'b0;
    logic [7:0]  resp = '0;
    logic [1:0]  err_code;

    always #5 clk = ~clk;

    cmd_sequencer #(
        .DEPTH       (DEPTH),
        .TIMEOUT_CYC (TMO),
        .MAX_RETRY   (MAXR)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (push),
        .push_cmd     (push_cmd),
        .push_data    (push_data),
        .push_rdy     (push_rdy),
        .ovf          (ovf),
        .send_cmd     (send_cmd),
        .cmd          (cmd),
        .data         (data),
        .resp_rdy     (resp_rdy),
        .resp         (resp),
        .clr_resp_rdy (clr_resp_rdy),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .err_code     (err_code)
    );

    int     n_vec = 0;
    int     n_bad = 0;
    longint cyc = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // ---------------- reference model (event schedule) ----------------
    typedef struct packed {
        logic send, done, err, clr, ovf, push_rdy, busy;
        logic [1:0]  code;
        logic [7:0]  cmd;
        logic [15:0] data;
    } exp_t;

    logic [23:0] mq[$];
    logic [23:0] m_cur;
    bit          m_inflight, m_await;
    longint      m_send_at, m_sent, m_verdict_at, m_free_at;
    int          m_tries;

    function automatic void model_reset();
        mq.delete();
        m_cur = '0; m_inflight = 0; m_await = 0;
        m_send_at = -1; m_sent = 0; m_verdict_at = -1; m_free_at = 0; m_tries = 0;
    endfunction

    function automatic exp_t model_step();
        exp_t e;
        bit fail;
        logic [1:0] fcode;
        bit pop_now;
        e = '0; fail = 0; fcode = ERR_NONE;
        if (!rst_n) begin
            model_reset();
            e.push_rdy = 1'b1;
            return e;
        end
        e.cmd      = m_cur[23:16];
        e.data     = m_cur[15:0];
        e.busy     = (mq.size() != 0) || m_inflight || (m_send_at == cyc);
        e.push_rdy = (mq.size() < int'(DEPTH));
        if (m_send_at == cyc) begin
            e.send = 1; m_inflight = 1; m_await = 1; m_sent = cyc; m_send_at = -1;
        end else if (m_await) begin
            if (resp_rdy) begin
                m_await = 0; m_verdict_at = cyc + 1;
            end else if (cyc - m_sent == longint'(TMO)) begin
                m_await = 0; fail = 1; fcode = ERR_TIMEOUT;
            end
        end else if (m_verdict_at == cyc) begin
            e.clr = 1; m_verdict_at = -1;
            if (resp == POS_ACK) begin
                e.done = 1; m_tries = 0; m_inflight = 0; m_free_at = cyc + 1;
            end else begin
                fail = 1; fcode = ERR_NAK;
            end
        end
        if (fail) begin
            if (RETRY && m_tries < int'(MAXR)) begin
                m_tries++; m_send_at = cyc + 1;
            end else begin
                e.err = 1; e.code = fcode; m_tries = 0; m_inflight = 0; m_free_at = cyc + 1;
            end
        end
        pop_now = (mq.size() != 0) && !m_inflight && (m_send_at < 0) && (cyc >= m_free_at);
        if (pop_now) begin
            m_cur = mq.pop_front();
            m_send_at = cyc + 1;
        end
        if (push) begin
            if (mq.size() < int'(DEPTH)) mq.push_back({push_cmd, push_data});
            else e.ovf = 1;
        end
        return e;
    endfunction

    // ---------------- cycle driver + responder ----------------
    logic        o_send, o_done, o_err, o_clr, o_ovf, o_busy, o_push_rdy;
    logic [1:0]  o_code;
    logic [7:0]  o_cmd;
    logic [15:0] o_data;
    logic [7:0]  sent_q[$];
    int          done_cnt = 0, err_cnt = 0;

    int          rsp_dly = 0;       // cycles after send_cmd that resp_rdy rises; 0 = never
    logic [7:0]  rsp_val = POS_ACK;
    bit          rsp_rand = 0;
    longint      resp_at = -1;
    logic [7:0]  pend_val = '0;

    task automatic cycle();
        exp_t e;
        int d;
        @(negedge clk);
        e = model_step();
        chk("send_cmd", send_cmd, e.send);
        chk("done", done, e.done);
        chk("err", err, e.err);
        chk("err_code", err_code, e.code);
        chk("clr_resp_rdy", clr_resp_rdy, e.clr);
        chk("ovf", ovf, e.ovf);
        chk("push_rdy", push_rdy, e.push_rdy);
        chk("busy", busy, e.busy);
        chk("cmd", cmd, e.cmd);
        chk("data", data, e.data);
        o_send = send_cmd; o_done = done; o_err = err; o_clr = clr_resp_rdy; o_ovf = ovf;
        o_busy = busy; o_push_rdy = push_rdy; o_code = err_code; o_cmd = cmd; o_data = data;
        if (send_cmd) sent_q.push_back(cmd);
        if (done) done_cnt++;
        if (err) err_cnt++;
        @(posedge clk);
        #1;
        cyc++;
        if (o_clr || !rst_n) resp_rdy = 1'b0;
        if (!rst_n) resp_at = -1;
        if (o_send && rst_n) begin
            d = rsp_rand ? int'($urandom_range(1, 12)) : rsp_dly;
            pend_val = rsp_rand ? (($urandom_range(0, 3) != 0) ? POS_ACK : 8'($urandom)) : rsp_val;
            resp_at = (d == 0) ? -1 : cyc - 1 + d;
        end
        if (resp_at == cyc) begin
            resp_rdy = 1'b1; resp = pend_val; resp_at = -1;
        end
    endtask

    task automatic push_one(input logic [7:0] c, input logic [15:0] dd);
        push = 1'b1; push_cmd = c; push_data = dd;
        cycle();
        push = 1'b0;
    endtask

    task automatic drain(input string nm);
        int k;
        k = 0;
        do begin
            cycle();
            k++;
        end while (o_busy && k < 20000);
        chk(nm, o_busy, 1'b0);
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [7:0]  c;
        logic [15:0] d;
        int          dly;
        logic [7:0]  rv;
        int          sends;
        logic        dn;
        logic        er;
        logic [1:0]  code;
        int          lat;      // first send_cmd to done/err pulse
    } vec_t;

    localparam int NV = 6;
    vec_t tv[NV];

    initial begin
        longint p, first, vcyc;
        int sends;
        logic got_done, got_err;
        logic [1:0] got_code;
        logic [7:0] fc;
        logic [15:0] fd;

        tv[0] = '{8'h05, 16'h00A0, 100, POS_ACK, 1, 1'b1, 1'b0, ERR_NONE, 101};
        tv[1] = '{8'h02, 16'h1234, 1, POS_ACK, 1, 1'b1, 1'b0, ERR_NONE, 2};
        tv[2] = '{8'h08, 16'hFFFF, 3, 8'h5A, RETRY ? 3 : 1, 1'b0, 1'b1, ERR_NAK, RETRY ? 14 : 4};
        tv[3] = '{8'h03, 16'h0000, 0, POS_ACK, RETRY ? 3 : 1, 1'b0, 1'b1, ERR_TIMEOUT, RETRY ? 3002 : 1000};
        tv[4] = '{8'h04, 16'hABCD, 1000, POS_ACK, 1, 1'b1, 1'b0, ERR_NONE, 1001};
        tv[5] = '{8'h06, 16'h5555, 999, POS_ACK, 1, 1'b1, 1'b0, ERR_NONE, 1000};

        model_reset();
        repeat (2) cycle();
        chk("reset_push_rdy", o_push_rdy, 1'b1);
        chk("reset_busy", o_busy, 1'b0);
        rst_n = 1'b1;
        repeat (2) cycle();

        for (int i = 0; i < NV; i++) begin
            rsp_dly = tv[i].dly; rsp_val = tv[i].rv; rsp_rand = 0;
            p = cyc;
            push_one(tv[i].c, tv[i].d);
            sends = 0; first = -1; vcyc = -1;
            got_done = 0; got_err = 0; got_code = '0; fc = '0; fd = '0;
            for (int k = 0; k < 4000 && vcyc < 0; k++) begin
                cycle();
                if (o_send) begin
                    sends++;
                    if (first < 0) begin first = cyc - 1; fc = o_cmd; fd = o_data; end
                end
                if (o_done || o_err) begin
                    vcyc = cyc - 1; got_done = o_done; got_err = o_err; got_code = o_code;
                end
            end
            chk("tbl_verdict_budget", 32'(vcyc >= 0), 1);
            repeat (3) begin
                cycle();
                if (o_send) sends++;
            end
            chk("tbl_push_to_send", 32'(first - p), 2);
            chk("tbl_cmd", fc, tv[i].c);
            chk("tbl_data", fd, tv[i].d);
            chk("tbl_sends", 32'(sends), 32'(tv[i].sends));
            chk("tbl_done", got_done, tv[i].dn);
            chk("tbl_err", got_err, tv[i].er);
            chk("tbl_err_code", got_code, tv[i].code);
            chk("tbl_latency", 32'(vcyc - first), 32'(tv[i].lat));
            chk("tbl_busy_after", o_busy, 1'b0);
        end

        // Six back-to-back pushes with a silent responder: the head is popped
        // early, so only the sixth finds the queue full.
        rsp_dly = 0; sent_q.delete();
        for (int i = 0; i < 6; i++) begin
            push_one(8'(8'h02 + i), 16'(16'h0100 * i));
            chk("burst_ovf", o_ovf, 1'(i == 5));
        end
        drain("burst_drain");
        chk("burst_send_count", 32'(sent_q.size()), 5);
        for (int i = 0; i < 5 && i < sent_q.size(); i++) begin
            chk("burst_order", sent_q[i], 8'(8'h02 + i));
        end

        // Reset while waiting for a response with two commands still queued.
        rsp_dly = 0;
        push_one(CMD_OP_02, 16'h0001);
        push_one(CMD_OP_03, 16'h0002);
        push_one(CMD_OP_04, 16'h0003);
        repeat (5) cycle();
        done_cnt = 0; err_cnt = 0; sent_q.delete();
        rst_n = 1'b0;
        cycle();
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_push_rdy", o_push_rdy, 1'b1);
        chk("rst_cmd", o_cmd, 8'h00);
        chk("rst_data", o_data, 16'h0000);
        cycle();
        rst_n = 1'b1;
        repeat (50) cycle();
        chk("rst_no_sends", 32'(sent_q.size()), 0);
        chk("rst_no_done", 32'(done_cnt), 0);
        chk("rst_no_err", 32'(err_cnt), 0);
        chk("rst_idle_busy", o_busy, 1'b0);

        // Randomized traffic against the model.
        rsp_rand = 1;
        for (int k = 0; k < 600; k++) begin
            push      = ($urandom_range(0, 2) == 0);
            push_cmd  = 8'($urandom_range(int'(CMD_OP_MIN), int'(CMD_OP_MAX)));
            push_data = 16'($urandom);
            cycle();
        end
        push = 1'b0;
        drain("random_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
